// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared state, next-PC select encodings and reset PC for the fetch unit
package pc_fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_next_pc_calc.sv
// rtl/pc_fetch_next_pc_calc.sv - combinational next-PC selection with word alignment
module next_pc_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pcsrc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_off_i,
    input  logic [31:0] jumpadd_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc4_o,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] target;

    assign pc4_o = pc_i + 32'd4;

    always_comb begin
        target = pc4_o;
        case (pcsrc_i)
            PC_SEQ:  target = pc4_o;
            PC_BR:   target = branch_taken_i ? (pc4_o + {branch_off_i[29:0], 2'b00}) : pc4_o;
            PC_J:    target = jumpadd_i;
            PC_JR:   target = jr_addr_i;
            default: target = pc4_o;
        endcase
    end

    // Low bits are dropped rather than faulting; the flag lets the core trap later.
    assign next_pc_o  = {target[31:2], 2'b00};
    assign misalign_o = |target[1:0];

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - two-state instruction fetch unit: request, capture, issue, advance PC
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsrc,
    input  logic        branch_taken,
    input  logic [31:0] branch_off,
    input  logic [31:0] jumpadd,
    input  logic [31:0] jr_addr,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  npc;
    logic         npc_misalign;

    next_pc_calc u_next_pc_calc (
        .pc_i           (pc_q),
        .pcsrc_i        (pcsrc),
        .branch_taken_i (branch_taken),
        .branch_off_i   (branch_off),
        .jumpadd_i      (jumpadd),
        .jr_addr_i      (jr_addr),
        .pc4_o          (pc4),
        .next_pc_o      (npc),
        .misalign_o     (npc_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    // Control inputs only matter on the ISSUE cycle that releases the PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_d       = npc;
                    misalign_d = npc_misalign;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Outputs are gated by rst so nothing is requested or issued while reset is held.
    assign imem_req    = !rst && (state_q == FETCH);
    assign instr_valid = !rst && (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - table-driven self-checking bench for pc_fetch with PC/instruction scoreboards
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsrc;
    logic        branch_taken;
    logic [31:0] branch_off;
    logic [31:0] jumpadd;
    logic [31:0] jr_addr;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pcsrc        (pcsrc),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jumpadd      (jumpadd),
        .jr_addr      (jr_addr),
        .stall        (stall),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pc4          (pc4),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pcsrc;
        logic        bt;
        logic [31:0] boff;
        logic [31:0] jadd;
        logic [31:0] jra;
        int          ack_delay;
        int          stall_cyc;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ctrl();
        pcsrc        = 2'($urandom);
        branch_taken = 1'($urandom);
        branch_off   = $urandom;
        jumpadd      = $urandom;
        jr_addr      = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] tag;
        logic [31:0] held_instr;

        // {pcsrc, taken, off, jumpadd, jr_addr, ack_delay, stall_cycles, expected pc, expected misalign}
        vecs[0]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0,         0, 0, 32'h0000_0004, 1'b0};
        vecs[1]  = '{2'b00, 1'b1, 32'h0000_0040, 32'h0000_0800, 32'h0000_0900, 3, 0, 32'h0000_0008, 1'b0};
        vecs[2]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0,         0, 2, 32'h0000_000C, 1'b0};
        vecs[3]  = '{2'b10, 1'b0, 32'h0,         32'h0000_0010, 32'h0000_0500, 1, 0, 32'h0000_0010, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0000_0700, 32'h0000_0600, 0, 0, 32'h0000_000C, 1'b0};
        vecs[5]  = '{2'b10, 1'b0, 32'h0,         32'h0000_0010, 32'h0,         0, 0, 32'h0000_0010, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0000_0700, 32'h0000_0600, 0, 1, 32'h0000_0014, 1'b0};
        vecs[7]  = '{2'b10, 1'b0, 32'h0,         32'h0040_0000, 32'h0,         0, 0, 32'h0040_0000, 1'b0};
        vecs[8]  = '{2'b10, 1'b1, 32'h0000_0004, 32'h0040_0100, 32'h0000_2000, 0, 0, 32'h0040_0100, 1'b0};
        vecs[9]  = '{2'b11, 1'b0, 32'h0,         32'h0040_0200, 32'h0000_1002, 0, 0, 32'h0000_1000, 1'b1};
        vecs[10] = '{2'b10, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0,         2, 0, 32'hFFFF_FFFC, 1'b0};
        vecs[11] = '{2'b00, 1'b1, 32'h0000_0100, 32'h0000_0300, 32'h0000_0400, 0, 0, 32'h0000_0000, 1'b0};
        vecs[12] = '{2'b01, 1'b1, 32'h0000_0003, 32'h0000_0333, 32'h0000_0444, 0, 0, 32'h0000_0010, 1'b0};
        vecs[13] = '{2'b10, 1'b0, 32'h0,         32'h0000_0013, 32'h0000_0020, 0, 0, 32'h0000_0010, 1'b1};

        rst = 1'b1;
        stall = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        scramble_ctrl();
        tick();
        tick();
        check("reset_req", {31'h0, imem_req}, 32'h0);
        check("reset_valid", {31'h0, instr_valid}, 32'h0);
        check("reset_pc", pc, 32'h0);
        check("reset_instr", instr, 32'h0);
        check("reset_misalign", {31'h0, misalign}, 32'h0);

        rst = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("first_req_after_reset", {31'h0, imem_req}, 32'h1);
        exp_pc_q.push_back(32'h0000_0000);

        for (int i = 0; i < NV; i++) begin
            if (exp_pc_q.size() == 0) begin
                check("pc_scoreboard_empty", 32'h1, 32'h0);
                cur_pc = pc;
            end else begin
                cur_pc = exp_pc_q.pop_front();
            end

            for (int d = 0; d < vecs[i].ack_delay; d++) begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                scramble_ctrl();
                #1;
                check($sformatf("v%0d_wait%0d_req", i, d), {31'h0, imem_req}, 32'h1);
                check($sformatf("v%0d_wait%0d_addr", i, d), imem_addr, cur_pc);
                tick();
            end
            check($sformatf("v%0d_fetch_req", i), {31'h0, imem_req}, 32'h1);
            check($sformatf("v%0d_fetch_addr", i), imem_addr, cur_pc);
            check($sformatf("v%0d_pc4", i), pc4, cur_pc + 32'd4);

            tag = 32'hA000_0000 | 32'(i);
            imem_ack = 1'b1;
            imem_rdata = tag;
            exp_instr_q.push_back(tag);
            tick();

            held_instr = (exp_instr_q.size() != 0) ? exp_instr_q.pop_front() : 32'hXXXX_XXXX;
            check($sformatf("v%0d_issue_valid", i), {31'h0, instr_valid}, 32'h1);
            check($sformatf("v%0d_issue_req", i), {31'h0, imem_req}, 32'h0);
            check($sformatf("v%0d_instr", i), instr, held_instr);
            check($sformatf("v%0d_issue_misalign", i), {31'h0, misalign}, 32'h0);

            for (int s = 0; s < vecs[i].stall_cyc; s++) begin
                stall = 1'b1;
                imem_ack = 1'b1;
                imem_rdata = $urandom;
                scramble_ctrl();
                tick();
                check($sformatf("v%0d_stall%0d_valid", i, s), {31'h0, instr_valid}, 32'h1);
                check($sformatf("v%0d_stall%0d_instr", i, s), instr, held_instr);
                check($sformatf("v%0d_stall%0d_pc", i, s), pc, cur_pc);
            end

            stall = 1'b0;
            imem_ack = 1'b1;
            imem_rdata = $urandom;
            pcsrc = vecs[i].pcsrc;
            branch_taken = vecs[i].bt;
            branch_off = vecs[i].boff;
            jumpadd = vecs[i].jadd;
            jr_addr = vecs[i].jra;
            exp_pc_q.push_back(vecs[i].exp_pc);
            tick();

            imem_ack = 1'b0;
            scramble_ctrl();
            check($sformatf("v%0d_next_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_instr_hold", i), instr, held_instr);
            check($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
        end

        // Reset while a fetch is pending, with an ack landing in the same cycle.
        cur_pc = (exp_pc_q.size() != 0) ? exp_pc_q.pop_front() : 32'hXXXX_XXXX;
        check("pre_reset_req", {31'h0, imem_req}, 32'h1);
        check("pre_reset_addr", imem_addr, cur_pc);
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rst_comb_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        tick();
        check("rst_hold_req", {31'h0, imem_req}, 32'h0);
        check("rst_hold_instr", instr, 32'h0);
        rst = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("post_rst_req", {31'h0, imem_req}, 32'h1);
        check("post_rst_addr", imem_addr, 32'h0);
        tick();
        check("post_rst_no_capture", instr, 32'h0);
        check("post_rst_still_fetch", {31'h0, imem_req}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: pcsrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 jr.
REQ-005 Port: branch_taken  input  1  branch condition result; qualifies pcsrc=01.
REQ-006 Port: branch_off  input  32  sign-extended branch immediate, word units.
REQ-007 Port: jumpadd  input  32  jump target from the jump-address composer.
REQ-008 Port: jr_addr  input  32  register-indirect target.
REQ-009 Port: stall  input  1  hold current instruction; blocks PC update.
REQ-010 Port: imem_ack  input  1  instruction memory returns data this cycle.
REQ-011 Port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 Port: imem_req  output  1  fetch request, held until acked.
REQ-013 Port: imem_addr  output  32  fetch address, equals pc.
REQ-014 Port: pc  output  32  current PC register.
REQ-015 Port: pc4  output  32  pc+4, feeds the jump-address composer.
REQ-016 Port: instr  output  32  captured instruction word.
REQ-017 Port: instr_valid  output  1  instr valid for decode this cycle.
REQ-018 Port: misalign  output  1  one-cycle pulse: selected target had addr[1:0]!=0.

Function
REQ-019 FSM states SHALL be FETCH and ISSUE only.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ack: instr<=imem_rdata, go ISSUE; else stay FETCH with req and address held stable.
REQ-021 ISSUE: instr_valid=1, imem_req=0; stall=1 -> stay ISSUE, instr and pc unchanged; stall=0 -> pc<=next_pc, go FETCH.
REQ-022 Minimum throughput SHALL be one instruction per 2 cycles (ack in first FETCH cycle).
REQ-023 next_pc: 00 -> pc+4; 01 -> branch_taken ? pc+4+(branch_off<<2) : pc+4; 10 -> jumpadd; 11 -> jr_addr.
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 pcsrc, branch_taken, branch_off, jumpadd, jr_addr SHALL be sampled only in ISSUE with stall=0; ignored otherwise.
REQ-026 Target with addr[1:0]!=0: pc SHALL load target with bits[1:0] forced to 00, misalign=1 for the following cycle only.
REQ-027 pc4 SHALL be combinational pc+4 at all times.
REQ-028 imem_ack while in ISSUE SHALL be ignored.
REQ-029 instr_valid and instr SHALL be unchanged by imem_rdata except on acked FETCH.

Reset
REQ-030 rst=1 at edge: pc<=RESET_PC, state<=FETCH, instr<=0, misalign<=0; overrides all other inputs.
REQ-031 While rst=1, imem_req=0 and instr_valid=0; first request in the cycle after rst falls.
REQ-032 Reset during pending FETCH SHALL abandon the request; an ack in the reset cycle SHALL not be captured.

Structure
REQ-033 Shared package SHALL hold the state enum, pcsrc encodings (PC_SEQ, PC_BR, PC_J, PC_JR), and RESET_PC default.
REQ-034 Combinational next-PC selection SHALL be a sub-module next_pc_calc; FSM and registers stay in pc_fetch.

Verification
REQ-035 Reset, ack every FETCH, pcsrc=00: pc sequence 0,4,8,C; instr_valid every 2nd cycle.
REQ-036 pc=0x0000_0010, pcsrc=01, branch_taken=1, branch_off=0xFFFF_FFFE -> next pc 0x0000_000C; branch_taken=0 -> 0x0000_0014.
REQ-037 pc=0x0040_0000, pcsrc=10, jumpadd=0x0040_0100 -> pc 0x0040_0100; pcsrc=11, jr_addr=0x0000_1002 -> pc 0x0000_1000, misalign pulses one cycle.
REQ-038 imem_ack withheld 3 cycles -> imem_req high 4 cycles, imem_addr stable; stall=1 for 2 ISSUE cycles -> instr, pc unchanged.
REQ-039 pc=0xFFFF_FFFC, pcsrc=00 -> pc 0x0000_0000.
REQ-040 rst asserted mid-FETCH with simultaneous ack -> pc=RESET_PC, instr=0, imem_req=0 during reset.
